// File: rtl/rv1_pkg.sv
// Shared core package: architectural widths and the
// writeback entry carried between execute and the register file.
package rv1_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match selector for writeback forwarding.
// Larger age means the entry sits closer to the tail.
module wb_fwd_match
  import rv1_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]                 vld_i,
  input  logic [N-1:0][REG_ADDR_W-1:0] addr_i,
  input  logic [N-1:0][AW-1:0]         age_i,
  input  logic [N-1:0][XLEN-1:0]       data_i,
  input  logic [REG_ADDR_W-1:0]        raddr_i,
  output logic                         hit_o,
  output logic [XLEN-1:0]              data_o
);

  logic            hit;
  logic [AW-1:0]   best;
  logic [XLEN-1:0] data;

  always_comb begin
    hit  = 1'b0;
    best = '0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (raddr_i != '0 && vld_i[i] &&
          addr_i[i] == raddr_i &&
          (!hit || age_i[i] > best)) begin
        hit  = 1'b1;
        best = age_i[i];
        data = data_i[i];
      end
    end
  end

  assign hit_o  = hit;
  assign data_o = data;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue: buffers results until the register-file
// write port is free and forwards pending values to readers.
module wb_queue
  import rv1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enq_val,
  output logic                    enq_rdy,
  input  logic [REG_ADDR_W-1:0]   enq_waddr,
  input  logic [XLEN-1:0]         enq_wdata,
  input  logic                    drain_en,
  output logic                    rf_wen,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic [REG_ADDR_W-1:0]   fwd_raddr,
  output logic                    fwd_hit,
  output logic [XLEN-1:0]         fwd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  wb_entry_t   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic non_empty;
  logic push;

  assign non_empty = count_q != '0;
  assign enq_rdy   = count_q != FULL;
  assign rf_wen    = drain_en && non_empty;
  assign rf_waddr  = non_empty ? mem_q[head_q].waddr : '0;
  assign rf_wdata  = non_empty ? mem_q[head_q].wdata : '0;
  assign count     = count_q;

  // x0 writes are accepted but never stored
  assign push = enq_val && enq_rdy && enq_waddr != '0;

  always_comb begin
    head_d  = rf_wen ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    unique case ({push, rf_wen})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[tail_q] <= '{waddr: enq_waddr, wdata: enq_wdata};
    end
  end

  logic [DEPTH-1:0]                 ent_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][PW-1:0]         ent_age;
  logic [DEPTH-1:0][XLEN-1:0]       ent_data;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_age[i]  = PW'(i) - head_q;
    assign ent_vld[i]  = {1'b0, ent_age[i]} < count_q;
    assign ent_addr[i] = mem_q[i].waddr;
    assign ent_data[i] = mem_q[i].wdata;
  end

  wb_fwd_match #(
    .N  (DEPTH),
    .AW (PW)
  ) u_match (
    .vld_i   (ent_vld),
    .addr_i  (ent_addr),
    .age_i   (ent_age),
    .data_i  (ent_data),
    .raddr_i (fwd_raddr),
    .hit_o   (fwd_hit),
    .data_o  (fwd_data)
  );

endmodule
